// File: rtl/kp_pkg.sv
// Shared keypad definitions: geometry, scan states, capture payload and
// the key codes used by the stopwatch control logic.
package kp_pkg;

   localparam int unsigned KP_ROWS     = 4;
   localparam int unsigned KP_COLS     = 4;
   localparam int unsigned KP_CODE_W   = 4;
   localparam logic [KP_COLS-1:0] KP_COL_IDLE = 4'b1111;

   localparam logic [KP_CODE_W-1:0] KEY_START = 4'hA;
   localparam logic [KP_CODE_W-1:0] KEY_CLEAR = 4'hB;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } kp_state_e;

   // Row pattern and key code latched when a single-row press is first seen.
   typedef struct packed {
      logic [KP_ROWS-1:0]   row;
      logic [KP_CODE_W-1:0] code;
   } kp_cap_t;

   function automatic logic single_low(input logic [KP_ROWS-1:0] r);
      return $countones(~r) == 1;
   endfunction

   function automatic logic [1:0] low_index(input logic [KP_ROWS-1:0] r);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < int'(KP_ROWS); i++) begin
         if (!r[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows; idles released (all high).
module row_sync
   import kp_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [KP_ROWS-1:0] row_in,
   output logic [KP_ROWS-1:0] row_s
);

   logic [KP_ROWS-1:0] meta_q;
   logic [KP_ROWS-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= KP_COL_IDLE;
         sync_q <= KP_COL_IDLE;
      end else begin
         meta_q <= row_in;
         sync_q <= meta_q;
      end
   end

   assign row_s = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes one active-low column at a time,
// debounces press and release, and reports one key code per press.
module keypad_scan
   import kp_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 4,
   parameter int unsigned DEBOUNCE_CNT = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [KP_ROWS-1:0]   key_row,
   output logic [KP_COLS-1:0]   key_col,
   output logic [KP_CODE_W-1:0] key_code,
   output logic                 key_valid,
   output logic                 key_pressed
);

   localparam int unsigned DIV_W = 8;
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);
   localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CNT);

   logic [KP_ROWS-1:0] row_s;

   kp_state_e            state_q,       state_d;
   logic [1:0]           col_idx_q,     col_idx_d;
   logic [DIV_W-1:0]     div_cnt_q,     div_cnt_d;
   logic [DEB_W-1:0]     deb_cnt_q,     deb_cnt_d;
   kp_cap_t              cap_q,         cap_d;
   logic [KP_COLS-1:0]   key_col_q,     key_col_d;
   logic [KP_CODE_W-1:0] key_code_q,    key_code_d;
   logic                 key_valid_q,   key_valid_d;
   logic                 key_pressed_q, key_pressed_d;
   logic [DEB_W-1:0]     deb_inc;

   row_sync u_row_sync (
      .clk    (clk),
      .rst    (rst),
      .row_in (key_row),
      .row_s  (row_s)
   );

   // Scan / debounce / hold sequencing; the column register follows col_idx_d
   // so the strobe never lags the index by a cycle.
   always_comb begin
      state_d       = state_q;
      col_idx_d     = col_idx_q;
      div_cnt_d     = div_cnt_q;
      deb_cnt_d     = deb_cnt_q;
      cap_d         = cap_q;
      key_code_d    = key_code_q;
      key_valid_d   = 1'b0;
      key_pressed_d = key_pressed_q;
      deb_inc       = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DEB_W'(1);

      unique case (state_q)
         SCAN: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (single_low(row_s)) begin
                  cap_d.row  = row_s;
                  cap_d.code = {low_index(row_s), col_idx_q};
                  deb_cnt_d  = '0;
                  state_d    = DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         DEBOUNCE: begin
            if (row_s != cap_q.row) begin
               col_idx_d = col_idx_q + 2'd1;
               div_cnt_d = '0;
               state_d   = SCAN;
            end else if (deb_cnt_q == DEB_LAST) begin
               key_code_d    = cap_q.code;
               key_valid_d   = 1'b1;
               key_pressed_d = 1'b1;
               deb_cnt_d     = '0;
               state_d       = HELD;
            end else begin
               deb_cnt_d = deb_inc;
            end
         end
         HELD: begin
            // Any low row, including a second key in this column, restarts release.
            if (row_s == KP_COL_IDLE) begin
               if (deb_cnt_q == DEB_LAST) begin
                  key_pressed_d = 1'b0;
                  deb_cnt_d     = '0;
                  col_idx_d     = col_idx_q + 2'd1;
                  div_cnt_d     = '0;
                  state_d       = SCAN;
               end else begin
                  deb_cnt_d = deb_inc;
               end
            end else begin
               deb_cnt_d = '0;
            end
         end
         default: begin
            state_d = SCAN;
         end
      endcase

      key_col_d = ~(KP_COLS'(1) << col_idx_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= SCAN;
         col_idx_q     <= 2'd0;
         div_cnt_q     <= '0;
         deb_cnt_q     <= '0;
         cap_q         <= '0;
         key_col_q     <= KP_COL_IDLE;
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
         key_pressed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_idx_q     <= col_idx_d;
         div_cnt_q     <= div_cnt_d;
         deb_cnt_q     <= deb_cnt_d;
         cap_q         <= cap_d;
         key_col_q     <= key_col_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_pressed_q <= key_pressed_d;
      end
   end

   assign key_col     = key_col_q;
   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a simulated key matrix, a behavioural scanner model
// checked every cycle, directed scenarios with literal expectations, random presses.
module tb_keypad_scan;
   import kp_pkg::*;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_row;
   logic [3:0] key_col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_pressed;

   logic [15:0] keys = 16'h0;   // bit r*4+c closes the switch at row r, column c

   int n_cmp = 0;
   int n_bad = 0;
   int valid_cnt = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_row     (key_row),
      .key_col     (key_col),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_pressed (key_pressed)
   );

   // Physical matrix: a closed switch pulls its row low while its column is strobed.
   always_comb begin
      key_row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
   end

   // ---------------- behavioural reference ----------------
   int         m_mode;   // 0 looking, 1 confirming press, 2 waiting for release
   int         m_col, m_dwell, m_run;
   logic [3:0] m_cap, m_code, hist0, hist1, rs;
   logic [3:0] e_col, e_code;
   logic       e_valid, e_pressed;

   function automatic int row_of(input logic [3:0] r);
      int idx = 0;
      for (int i = 0; i < 4; i++) if (!r[i]) idx = i;
      return idx;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_col = 0; m_dwell = 0; m_run = 0;
         m_cap = 4'hF; m_code = 4'h0; hist0 = 4'hF; hist1 = 4'hF;
         e_col = 4'hF; e_code = 4'h0; e_valid = 1'b0; e_pressed = 1'b0;
      end else begin
         rs = hist1;   // rows as seen two clocks ago
         e_valid = 1'b0;
         case (m_mode)
            0: begin
               if (m_dwell == SCAN_DIV - 1) begin
                  m_dwell = 0;
                  if ($countones(~rs) == 1) begin
                     m_cap  = rs;
                     m_code = 4'(row_of(rs) * 4 + m_col);
                     m_run  = 0;
                     m_mode = 1;
                  end else m_col = (m_col + 1) % 4;
               end else m_dwell++;
            end
            1: begin
               if (rs != m_cap) begin
                  m_mode = 0; m_col = (m_col + 1) % 4;
               end else if (m_run == DEB - 1) begin
                  e_code = m_code; e_valid = 1'b1; e_pressed = 1'b1;
                  m_run = 0; m_mode = 2;
               end else m_run++;
            end
            default: begin
               if (rs == 4'hF) begin
                  if (m_run == DEB - 1) begin
                     e_pressed = 1'b0; m_run = 0; m_mode = 0;
                     m_col = (m_col + 1) % 4;
                  end else m_run++;
               end else m_run = 0;
            end
         endcase
         e_col = ~(4'b0001 << m_col);
         hist1 = hist0;
         hist0 = key_row;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("key_col",     32'(key_col),     32'(e_col));
         check("key_code",    32'(key_code),    32'(e_code));
         check("key_valid",   32'(key_valid),   32'(e_valid));
         check("key_pressed", 32'(key_pressed), 32'(e_pressed));
         if (key_valid === 1'b1) valid_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic wait_col(input logic [3:0] col, input string name);
      int n = 0;
      while (key_col !== col && n < 40) begin cyc(1); n++; end
      check(name, 32'(key_col == col), 32'd1);
   endtask

   task automatic wait_pressed(input logic lvl, input int max, input string name, output int n);
      n = 0;
      while (key_pressed !== lvl && n < max) begin cyc(1); n++; end
      check(name, 32'(key_pressed), 32'(lvl));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_col"},     32'(key_col),     32'hF);
      check({tag, "_valid"},   32'(key_valid),   32'd0);
      check({tag, "_pressed"}, 32'(key_pressed), 32'd0);
      check({tag, "_code"},    32'(key_code),    32'd0);
   endtask

   initial begin
      int n;
      logic [3:0] exp_c;
      logic [3:0] seen;

      // 1) reset and column walk
      @(posedge clk); #1 cmp_en = 1'b1;
      cyc(2);
      check_reset_outputs("rst");
      rst = 1'b0;
      for (int k = 0; k < 19; k++) begin
         cyc(1);
         exp_c = ~(4'b0001 << (((k + 1) / 4) % 4));
         check("walk", 32'(key_col), 32'(exp_c));
      end

      // 2) clean press row 2 / column 1
      wait_col(4'b1101, "t2_reach_col");
      keys = 16'h0; keys[9] = 1'b1; valid_cnt = 0;
      cyc(40);
      check("t2_valid_count", 32'(valid_cnt), 32'd1);
      check("t2_code", 32'(key_code), 32'h9);
      check("t2_pressed", 32'(key_pressed), 32'd1);
      keys = 16'h0;
      wait_pressed(1'b0, 40, "t2_release", n);
      check("t2_release_cycles", 32'(n), 32'd22);
      cyc(8);

      // 3) bouncing press row 0 / column 3
      wait_col(4'b0111, "t3_reach_col");
      valid_cnt = 0;
      for (int i = 0; i < 5; i++) begin keys[3] = ~keys[3]; cyc(3); end
      check("t3_bounce_valid", 32'(valid_cnt), 32'd0);
      cyc(40);
      check("t3_valid_count", 32'(valid_cnt), 32'd1);
      check("t3_code", 32'(key_code), 32'h3);
      keys = 16'h0;
      wait_pressed(1'b0, 40, "t3_release", n);
      cyc(8);

      // 4) ghost: two rows low on column 0
      keys = 16'h0; keys[0] = 1'b1; keys[4] = 1'b1;
      valid_cnt = 0; seen = 4'h0;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         for (int c = 0; c < 4; c++) if (!key_col[c]) seen[c] = 1'b1;
      end
      check("t4_ghost_valid", 32'(valid_cnt), 32'd0);
      check("t4_cols_seen", 32'(seen), 32'hF);
      keys = 16'h0;
      cyc(6);

      // 5) release glitch on KEY_START
      keys[KEY_START] = 1'b1;
      wait_pressed(1'b1, 60, "t5_press", n);
      check("t5_code", 32'(key_code), 32'(KEY_START));
      cyc(5);
      keys = 16'h0; n = 0;
      while (key_pressed === 1'b1 && n < 60) begin
         cyc(1); n++;
         if (n == 15) keys[KEY_START] = 1'b1;
         if (n == 16) keys[KEY_START] = 1'b0;
      end
      check("t5_release_cycles", 32'(n), 32'd38);
      cyc(8);

      // 6) reset while confirming KEY_CLEAR
      keys[KEY_CLEAR] = 1'b1; n = 0;
      while (!(m_mode == 1 && m_run == 10) && n < 60) begin cyc(1); n++; end
      check("t6_reach_deb10", 32'(m_mode == 1 && m_run == 10), 32'd1);
      valid_cnt = 0;
      rst = 1'b1;
      cyc(1);
      check_reset_outputs("t6");
      keys = 16'h0;
      cyc(2);
      rst = 1'b0;
      cyc(40);
      check("t6_no_valid", 32'(valid_cnt), 32'd0);

      // random presses, bounces and multi-key chords against the model
      for (int s = 0; s < 14; s++) begin
         int kind = int'($urandom_range(0, 9));
         keys = 16'h0;
         keys[$urandom_range(0, 15)] = 1'b1;
         if (kind == 6) keys[$urandom_range(0, 15)] = 1'b1;
         if (kind == 7) keys = 16'h0;
         if (kind >= 8) begin
            logic [15:0] k = keys;
            for (int b = 0; b < 4; b++) begin
               cyc(int'($urandom_range(1, 4)));
               keys = (keys == 16'h0) ? k : 16'h0;
            end
            keys = k;
         end
         cyc(int'($urandom_range(5, 60)));
         keys = 16'h0;
         cyc(int'($urandom_range(5, 40)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
